pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, flush, and bubble insertion. It replaces the fixed-width, stall-vector-driven inter-stage registers between core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Each stage is one instance carrying an opaque payload bus. An optional skid buffer decouples the upstream ready path from downstream backpressure.

## Interface
- DATA_W, default 32: payload width in bits; must be ≥ 1.
- NOP_VAL, default {DATA_W{1'b0}}: payload driven while the stage holds no valid entry (the bubble).
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- flush_i  input  1  discards all held entries; highest priority.
- in_valid_i  input  1  upstream presents a payload.
- in_ready_o  output  1  stage can accept a payload this cycle.
- in_data_i  input  DATA_W  upstream payload.
- out_valid_o  output  1  stage presents a payload downstream.
- out_ready_i  input  1  downstream accepts this cycle.
- out_data_o  output  DATA_W  downstream payload; equals NOP_VAL whenever out_valid_o=0.
- occupancy_o  output  2  number of held entries (0..2).

## Operation
- Input transfer occurs when in_valid_i & in_ready_o; output transfer occurs when out_valid_o & out_ready_i.
- The main register drives out_data_o. The skid register is present only with the skid feature enabled.
- The state machine has three states: EMPTY (occ 0), FULL (occ 1), SKID (occ 2).
- EMPTY: in_ready_o=1.
  - in_valid_i → FULL; main register loads in_data_i.
- FULL: in_ready_o=1.
  - in_valid_i & out_ready_i → FULL; main register loads in_data_i.
  - in_valid_i & !out_ready_i → SKID; skid register loads in_data_i.
  - !in_valid_i & out_ready_i → EMPTY; main register ← NOP_VAL.
  - Otherwise hold.
- SKID: in_ready_o=0.
  - out_ready_i → FULL; main register loads the skid contents, and the skid register ← NOP_VAL.
  - Otherwise hold.
- Flush overrides every transition:
  - Next state is EMPTY; both registers ← NOP_VAL.
  - An input handshake in the same cycle counts as accepted and is discarded.
  - An output handshake in the same cycle completes normally.
- Holding means the payload is stable bit-for-bit until transferred. No entry is ever duplicated or dropped except by flush.
- Reset (any time, including mid-transfer): state EMPTY, out_valid_o=0, out_data_o=NOP_VAL, in_ready_o=1, occupancy_o=0, skid register=NOP_VAL.

## Timing
- Latency: 1 cycle from input transfer to out_valid_o when the stage is empty.
- Throughput: 1 entry per cycle while out_ready_i=1.
- With the skid feature enabled, in_ready_o is a registered signal (equivalent to state≠SKID). There is no combinational path from out_ready_i to in_ready_o.
- out_valid_o and out_data_o are always registered outputs.
- occupancy_o is registered and matches the state encoding.
- Simultaneous flush_i and rst: reset dominates (asynchronous).
- Deasserting rst releases the stage on the next rising edge; the first input transfer is possible in that same cycle.

## Configuration
- PIPE_SKID_EN, defined: skid register and SKID state are present, and in_ready_o is registered as described above.
- PIPE_SKID_EN, undefined:
  - Only EMPTY and FULL exist, with no skid register.
  - in_ready_o = out_ready_i | !out_valid_o (combinational).
  - occupancy_o never exceeds 1; the FULL & in_valid_i & !out_ready_i case is unreachable.
  - All other rules are unchanged.

## Structure
- Shared package/defines file holds:
  - state encodings PIPE_EMPTY=2'd0, PIPE_FULL=2'd1, PIPE_SKID=2'd2;
  - occupancy width constant PIPE_OCC_W=2.
- Sub-module pipe_skid_buf holds the skid register and its load/clear logic. It is instantiated only under PIPE_SKID_EN.
- The top level owns the FSM, the main register, and the output muxing.

## Test plan
All scenarios use DATA_W=32 and NOP_VAL=0.
- Reset: assert rst mid-stream with occupancy 2 → outputs immediately show out_valid_o=0, out_data_o=0, in_ready_o=1, occupancy_o=0.
- Streaming: send 0x11, 0x22, 0x33 on consecutive cycles with out_ready_i=1 → identical values appear one cycle later, back-to-back, occupancy_o=1 throughout.
- Backpressure (PIPE_SKID_EN): hold out_ready_i=0 and send 0xA1, 0xA2 → occupancy_o reaches 2, in_ready_o=0, and 0xA3 is held upstream. Release out_ready_i → outputs 0xA1, 0xA2, 0xA3 in order with no loss or duplication.
- Backpressure (no skid): with out_ready_i=0 and a held entry → in_ready_o=0 in the same cycle; the entry stays stable across 5 stalled cycles.
- Flush: at occupancy 2, assert flush_i together with in_valid_i=1 and data 0xFF → next cycle EMPTY, out_data_o=0, and 0xFF never emerges.
- Drain to bubble: a single entry 0x5 is followed by idle input → after 0x5 transfers, out_valid_o=0 and out_data_o=0 on the next cycle.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared state encodings and widths for the pipeline stage register.
// Used by pipe_stage_reg and pipe_skid_buf.
package pipe_stage_reg_pkg;

    localparam int PIPE_OCC_W = 2;

    typedef enum logic [PIPE_OCC_W-1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_FULL  = 2'd1,
        PIPE_SKID  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Second-entry holding register for the pipeline stage.
// Captures a payload while the main register is stalled. Clearing it wins over loading it.
module pipe_skid_buf #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] skid_q, skid_d;

    always_comb begin
        skid_d = skid_q;
        if (clear_i)
            skid_d = NOP_VAL;
        else if (load_i)
            skid_d = data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            skid_q <= NOP_VAL;
        else
            skid_q <= skid_d;
    end

    assign data_o = skid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, and bubble insertion.
// The optional skid buffer is enabled with `define PIPE_SKID_EN.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_W-1:0]     out_data_o,
    output logic [PIPE_OCC_W-1:0] occupancy_o
);

    pipe_state_e       state_q;
    logic [DATA_W-1:0] main_q;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_data;
    logic              skid_load, skid_clear;

    // A second entry is parked only when the main register is stalled.
    assign skid_load  = !flush_i && (state_q == PIPE_FULL) && in_valid_i && !out_ready_i;
    assign skid_clear = flush_i || ((state_q == PIPE_SKID) && out_ready_i);

    pipe_skid_buf #(
        .DATA_W  (DATA_W),
        .NOP_VAL (NOP_VAL)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_data_i),
        .data_o  (skid_data)
    );

    assign in_ready_o = (state_q != PIPE_SKID);
`else
    assign in_ready_o = out_ready_i || !out_valid_o;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PIPE_EMPTY;
            main_q  <= NOP_VAL;
        end else if (flush_i) begin
            state_q <= PIPE_EMPTY;
            main_q  <= NOP_VAL;
        end else begin
            unique case (state_q)
                PIPE_EMPTY: begin
                    if (in_valid_i) begin
                        state_q <= PIPE_FULL;
                        main_q  <= in_data_i;
                    end
                end
                PIPE_FULL: begin
                    if (in_valid_i && out_ready_i)
                        main_q <= in_data_i;
`ifdef PIPE_SKID_EN
                    else if (in_valid_i)
                        state_q <= PIPE_SKID;
`endif
                    else if (!in_valid_i && out_ready_i) begin
                        state_q <= PIPE_EMPTY;
                        main_q  <= NOP_VAL;
                    end
                end
`ifdef PIPE_SKID_EN
                PIPE_SKID: begin
                    if (out_ready_i) begin
                        state_q <= PIPE_FULL;
                        main_q  <= skid_data;
                    end
                end
`endif
                default: begin
                    state_q <= PIPE_EMPTY;
                    main_q  <= NOP_VAL;
                end
            endcase
        end
    end

    assign out_valid_o = (state_q != PIPE_EMPTY);
    assign out_data_o  = out_valid_o ? main_q : NOP_VAL;
    assign occupancy_o = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (DATA_W=32, NOP_VAL=0); follows PIPE_SKID_EN when defined.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [31:0] in_data_i, out_data_o;
    logic [1:0]  occupancy_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .NOP_VAL(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .occupancy_o (occupancy_o)
    );

    typedef struct {
        logic        rst, fl, iv;
        logic [31:0] id;
        logic        ordy;
        logic        ov;
        logic [31:0] od;
        logic        ir;
        logic [1:0]  occ;
    } vec_t;

    vec_t tbl[10];

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
    task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] id,
                         input logic ordy);
        @(negedge clk);
        rst = r; flush_i = f; in_valid_i = iv; in_data_i = id; out_ready_i = ordy;
        #1;
    endtask

    task automatic chk(input string nm, input logic ov, input logic [31:0] od,
                       input logic ir, input logic [1:0] occ);
        n_vec++;
        if (out_valid_o !== ov || out_data_o !== od || in_ready_o !== ir || occupancy_o !== occ) begin
            n_err++;
            $display("FAIL %s: got ov=%b od=%h ir=%b occ=%0d, want ov=%b od=%h ir=%b occ=%0d",
                     nm, out_valid_o, out_data_o, in_ready_o, occupancy_o, ov, od, ir, occ);
        end
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;

        //           rst   fl    iv    id     ordy  ov    od     ir    occ
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b1, 2'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 1'b0, 32'h0,  1'b1, 2'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 32'h11, 1'b1, 2'd1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 32'h22, 1'b1, 2'd1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h33, 1'b1, 2'd1};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 2'd0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h5,  1'b0, 1'b0, 32'h0,  1'b1, 2'd0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h5,  SKID, 2'd1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h5,  1'b1, 2'd1};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 2'd0};

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            chk($sformatf("tbl%0d", i), tbl[i].ov, tbl[i].od, tbl[i].ir, tbl[i].occ);
        end

`ifdef PIPE_SKID_EN
        // Backpressure: A1 in main, A2 parked, A3 held upstream until space opens.
        drive(0, 0, 1, 32'hA1, 0); chk("bp_a1_in",   0, 32'h0,  1, 0);
        drive(0, 0, 1, 32'hA2, 0); chk("bp_a2_in",   1, 32'hA1, 1, 1);
        drive(0, 0, 1, 32'hA3, 0); chk("bp_full",    1, 32'hA1, 0, 2);
        drive(0, 0, 1, 32'hA3, 0); chk("bp_hold",    1, 32'hA1, 0, 2);
        drive(0, 0, 1, 32'hA3, 1); chk("bp_out_a1",  1, 32'hA1, 0, 2);
        drive(0, 0, 1, 32'hA3, 1); chk("bp_out_a2",  1, 32'hA2, 1, 1);
        drive(0, 0, 0, 32'h0,  1); chk("bp_out_a3",  1, 32'hA3, 1, 1);
        drive(0, 0, 0, 32'h0,  1); chk("bp_drained", 0, 32'h0,  1, 0);

        // Flush at occupancy 2 with a simultaneous 0xFF offer.
        drive(0, 0, 1, 32'hB1, 0); chk("fl_b1",      0, 32'h0,  1, 0);
        drive(0, 0, 1, 32'hB2, 0); chk("fl_b2",      1, 32'hB1, 1, 1);
        drive(0, 1, 1, 32'hFF, 1); chk("fl_at_occ2", 1, 32'hB1, 0, 2);
        drive(0, 0, 0, 32'h0,  1); chk("fl_empty",   0, 32'h0,  1, 0);
        drive(0, 0, 0, 32'h0,  1); chk("fl_no_ff",   0, 32'h0,  1, 0);

        // Asynchronous reset while occupancy is 2.
        drive(0, 0, 1, 32'hC1, 0); chk("rs_c1",      0, 32'h0,  1, 0);
        drive(0, 0, 1, 32'hC2, 0); chk("rs_c2",      1, 32'hC1, 1, 1);
        drive(0, 0, 0, 32'h0,  0); chk("rs_occ2",    1, 32'hC1, 0, 2);
        drive(1, 0, 0, 32'h0,  0); chk("rs_async",   0, 32'h0,  1, 0);
        // Reset released: skid contents must not reappear.
        drive(0, 0, 1, 32'hD1, 1); chk("rs_release", 0, 32'h0,  1, 0);
        drive(0, 0, 0, 32'h0,  1); chk("rs_d1",      1, 32'hD1, 1, 1);
        drive(0, 0, 0, 32'h0,  1); chk("rs_after",   0, 32'h0,  1, 0);
`else
        // Backpressure: held entry stays stable over 5 stalled cycles, next offer waits.
        drive(0, 0, 1, 32'h77, 0); chk("bp_load", 0, 32'h0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 32'h88, 0);
            chk($sformatf("bp_stall%0d", i), 1, 32'h77, 0, 1);
        end
        drive(0, 0, 1, 32'h88, 1); chk("bp_out_77",  1, 32'h77, 1, 1);
        drive(0, 0, 0, 32'h0,  1); chk("bp_out_88",  1, 32'h88, 1, 1);
        drive(0, 0, 0, 32'h0,  1); chk("bp_drained", 0, 32'h0,  1, 0);

        // Flush with a held entry and a simultaneous 0xFF offer.
        drive(0, 0, 1, 32'hB1, 0); chk("fl_b1",      0, 32'h0,  1, 0);
        drive(0, 1, 1, 32'hFF, 0); chk("fl_at_occ1", 1, 32'hB1, 0, 1);
        drive(0, 0, 0, 32'h0,  1); chk("fl_empty",   0, 32'h0,  1, 0);
        drive(0, 0, 0, 32'h0,  1); chk("fl_no_ff",   0, 32'h0,  1, 0);

        // Asynchronous reset with a held entry.
        drive(0, 0, 1, 32'hC1, 0); chk("rs_c1",      0, 32'h0,  1, 0);
        drive(0, 0, 0, 32'h0,  0); chk("rs_held",    1, 32'hC1, 0, 1);
        drive(1, 0, 0, 32'h0,  0); chk("rs_async",   0, 32'h0,  1, 0);
        drive(0, 0, 1, 32'hD1, 1); chk("rs_release", 0, 32'h0,  1, 0);
        drive(0, 0, 0, 32'h0,  1); chk("rs_d1",      1, 32'hD1, 1, 1);
        drive(0, 0, 0, 32'h0,  1); chk("rs_after",   0, 32'h0,  1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
